// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its high time
// (duty) and rise-to-rise period in clk cycles. A stuck input is reported
// through a timeout pulse once the cycle counter reaches its maximum.
module pwm_capture #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  logic             w_rise;
  logic             w_fall;
  logic             w_to_hit;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic             r_locked;

  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_hi_cnt_next;
  logic [CNT_W-1:0] w_duty_next;
  logic [CNT_W-1:0] w_period_next;
  logic             w_valid_next;
  logic             w_timeout_next;
  logic             w_locked_next;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= pwm_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_prev;
  assign w_fall = ~r_s2 & r_prev;

  // A rise on the last counter value still closes a normal period, so the
  // timeout only fires when no rise arrives at MAX.
  assign w_to_hit = en && (r_state != IDLE) && (r_cnt == MAX) && !w_rise;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; en low always forces IDLE, timeout always restarts SEEK.
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else if (w_to_hit) begin
      w_state_next = SEEK;
    end else begin
      case (r_state)
        IDLE:    w_state_next = SEEK;
        SEEK:    if (w_rise) w_state_next = HIGH;
        HIGH:    if (w_fall) w_state_next = LOW;
        LOW:     if (w_rise) w_state_next = HIGH;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath/output next values: counting, capture, valid/timeout pulses.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_hi_cnt_next  = r_hi_cnt;
    w_duty_next    = r_duty;
    w_period_next  = r_period;
    w_valid_next   = 1'b0;
    w_timeout_next = 1'b0;
    w_locked_next  = r_locked;
    if (!en) begin
      w_cnt_next    = '0;
      w_hi_cnt_next = '0;
      w_locked_next = 1'b0;
    end else if (r_state == IDLE) begin
      w_cnt_next = '0;
    end else if (w_to_hit) begin
      w_timeout_next = 1'b1;
      w_locked_next  = 1'b0;
      w_period_next  = MAX;
      w_duty_next    = r_s2 ? MAX : '0;
      w_cnt_next     = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
      case (r_state)
        SEEK: begin
          if (w_rise) w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end
        HIGH: begin
          if (w_fall) w_hi_cnt_next = r_cnt;
        end
        LOW: begin
          if (w_rise) begin
            w_duty_next   = r_hi_cnt;
            w_period_next = r_cnt;
            w_valid_next  = 1'b1;
            w_locked_next = 1'b1;
            w_cnt_next    = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_hi_cnt  <= '0;
      r_duty    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_hi_cnt  <= w_hi_cnt_next;
      r_duty    <= w_duty_next;
      r_period  <= w_period_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
      r_locked  <= w_locked_next;
    end
  end

  assign duty    = r_duty;
  assign period  = r_period;
  assign valid   = r_valid;
  assign timeout = r_timeout;
  assign locked  = r_locked;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: drives PWM patterns and checks
// captured duty/period, valid/timeout pulse counts, timing and locked.
module tb_pwm_capture;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             locked;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_to = 0;
  int n_d5 = 0;
  int n_d12 = 0;
  int n_dother = 0;
  int v_cyc_last = 0;
  int v_cyc_prev = 0;
  int t_cyc_last = 0;
  int t_cyc_prev = 0;
  int rise_cyc = 0;

  int bv, bt, b5, b12, bo, c0;

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pwm_in  (pwm_in),
    .duty    (duty),
    .period  (period),
    .valid   (valid),
    .timeout (timeout),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid    <= n_valid + 1;
      v_cyc_prev <= v_cyc_last;
      v_cyc_last <= cyc;
      if (duty == 8'd5)       n_d5 <= n_d5 + 1;
      else if (duty == 8'd12) n_d12 <= n_d12 + 1;
      else                    n_dother <= n_dother + 1;
    end
    if (timeout) begin
      n_to       <= n_to + 1;
      t_cyc_prev <= t_cyc_last;
      t_cyc_last <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-20s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Hold pwm_in at v for n cycles; entered and left at 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_pwm(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      rise_cyc = cyc;
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    hold(1'b0, 4);
    en = 1'b1;
    hold(1'b0, 4);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", duty, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;
    hold(1'b0, 3);

    // 5 high / 11 low
    en = 1'b1;
    hold(1'b0, 4);
    bv = n_valid; bt = n_to;
    run_pwm(5, 11, 6);
    hold(1'b0, 5);
    chk("t1_valid_cnt", n_valid - bv, 5);
    chk("t1_duty", duty, 5);
    chk("t1_period", period, 16);
    chk("t1_locked", locked, 1);
    chk("t1_valid_spacing", v_cyc_last - v_cyc_prev, 16);
    chk("t1_valid_latency", v_cyc_last - rise_cyc, 3);
    chk("t1_timeouts", n_to - bt, 0);

    // 15 high / 1 low
    restart();
    bv = n_valid;
    run_pwm(15, 1, 4);
    hold(1'b0, 5);
    chk("t2a_valid_cnt", n_valid - bv, 3);
    chk("t2a_duty", duty, 15);
    chk("t2a_period", period, 16);

    // 1 high / 1 low
    restart();
    bv = n_valid;
    run_pwm(1, 1, 8);
    hold(1'b0, 5);
    chk("t2b_valid_cnt", n_valid - bv, 7);
    chk("t2b_duty", duty, 1);
    chk("t2b_period", period, 2);
    chk("t2b_valid_spacing", v_cyc_last - v_cyc_prev, 2);

    // stuck low
    en = 1'b0;
    hold(1'b0, 4);
    bv = n_valid; bt = n_to;
    en = 1'b1;
    c0 = cyc;
    hold(1'b0, 600);
    chk("t3a_timeouts", n_to - bt, 2);
    chk("t3a_first_to", t_cyc_prev - c0, 257);
    chk("t3a_to_spacing", t_cyc_last - t_cyc_prev, 256);
    chk("t3a_duty", duty, 0);
    chk("t3a_period", period, 255);
    chk("t3a_valid_cnt", n_valid - bv, 0);
    chk("t3a_locked", locked, 0);

    // stuck high
    restart();
    bv = n_valid; bt = n_to;
    c0 = cyc;
    hold(1'b1, 600);
    chk("t3b_timeouts", n_to - bt, 2);
    chk("t3b_first_to", t_cyc_prev - c0, 258);
    chk("t3b_to_spacing", t_cyc_last - t_cyc_prev, 256);
    chk("t3b_duty", duty, 255);
    chk("t3b_period", period, 255);
    chk("t3b_valid_cnt", n_valid - bv, 0);

    // en dropped mid-HIGH
    restart();
    run_pwm(5, 11, 4);
    chk("t4_locked_before", locked, 1);
    bv = n_valid;
    hold(1'b1, 2);
    en = 1'b0;
    hold(1'b1, 3);
    hold(1'b0, 7);
    chk("t4_valid_en0", n_valid - bv, 0);
    chk("t4_locked_en0", locked, 0);
    chk("t4_duty_hold", duty, 5);
    chk("t4_period_hold", period, 16);
    en = 1'b1;
    hold(1'b0, 4);
    bv = n_valid;
    run_pwm(5, 11, 3);
    hold(1'b0, 5);
    chk("t4_valid_relock", n_valid - bv, 2);
    chk("t4_locked_after", locked, 1);

    // asynchronous reset during LOW
    restart();
    run_pwm(5, 11, 3);
    hold(1'b1, 5);
    hold(1'b0, 4);
    chk("t5_locked_pre", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_duty", duty, 0);
    chk("t5_rst_period", period, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_timeout", timeout, 0);
    chk("t5_rst_locked", locked, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b0, 4);
    bv = n_valid;
    run_pwm(5, 11, 3);
    hold(1'b0, 5);
    chk("t5_valid_cnt", n_valid - bv, 2);
    chk("t5_duty", duty, 5);
    chk("t5_period", period, 16);

    // duty change 5 -> 12 with one transition period of 8 high
    restart();
    bv = n_valid; b5 = n_d5; b12 = n_d12; bo = n_dother;
    run_pwm(5, 11, 3);
    run_pwm(8, 8, 1);
    run_pwm(12, 4, 4);
    hold(1'b0, 5);
    chk("t6_valid_cnt", n_valid - bv, 7);
    chk("t6_duty5_cnt", n_d5 - b5, 3);
    chk("t6_intermediate", n_dother - bo, 1);
    chk("t6_duty12_cnt", n_d12 - b12, 3);
    chk("t6_duty", duty, 12);
    chk("t6_period", period, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
